vram_write_arbiter: RTL and testbench
=====================================

// Module: vram_write_arbiter
// PURPOSE
//  Shares the single VRAM write port between two writers: port 0 = VGA command controller (char/clear/bitmap),
//  port 1 = a second engine (e.g. scroll/blit). Round-robin grant with bounded bursts feeds a 1-entry registered
//  output stage. The stage holds REQ/ADDR/DATA stable while iVRAM_WAIT is high. Sits between the writers and the VRAM controller.
// PARAMETERS
//  P_MAX_BURST  16  max consecutive accepted writes per grant before the grant must be re-arbitrated (>=1)
//  P_CNT_W      4   burst counter width, clog2(P_MAX_BURST)
// PORTS
//  iCLOCK            in   1   clock
//  inRESET           in   1   asynchronous active-low reset
//  iREQ0_REQ         in   1   port 0 write request; ADDR/DATA held stable until accepted
//  iREQ0_ADDR        in   19  port 0 VRAM pixel address
//  iREQ0_DATA        in   16  port 0 pixel data (RGB565)
//  oREQ0_WAIT        out  1   port 0 stall; REQ&&!WAIT in a cycle = write accepted that cycle
//  iREQ1_REQ/ADDR/DATA, oREQ1_WAIT   same as port 0, for port 1
//  oVRAM_WRITE_REQ   out  1   output stage valid
//  oVRAM_WRITE_ADDR  out  19  output stage address
//  oVRAM_WRITE_DATA  out  16  output stage data
//  iVRAM_WAIT        in   1   VRAM busy; write transfers on cycle with oVRAM_WRITE_REQ && !iVRAM_WAIT
//  oGRANT            out  2   current grant, one-hot {port1,port0}; 2'b00 when idle
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, last=1 (port 0 wins first tie), burst count=0, out valid=0,
//   ADDR/DATA=0, oREQ0_WAIT=oREQ1_WAIT=1, oGRANT=0. Pending stage data is discarded.
//  States: IDLE, GNT0, GNT1 (registered).
//  IDLE: only REQ0 -> GNT0; only REQ1 -> GNT1; both -> port != last; none -> stay. No accept in IDLE.
//  Accept (combinational): acc_n = (state==GNTn) && iREQn_REQ && (!valid || !iVRAM_WAIT).
//   oREQn_WAIT = !acc_n (always high for the non-granted port).
//  Output stage: on acc_n load ADDR/DATA from port n and set valid=1.
//   Else if valid && !iVRAM_WAIT then valid=0. Hold everything while iVRAM_WAIT=1.
//   Drain and refill in the same cycle is allowed, so throughput is 1 write/clk.
//  GNTn transitions (evaluated every cycle, priority order):
//   1. acc_n && cnt==P_MAX_BURST-1: cnt=0, last=n. Go to GNT(other) if other REQ is high, else IDLE.
//      If only port n is requesting, it is re-granted through IDLE.
//   2. !iREQn_REQ: cnt=0, last=n. Go to GNT(other) if other REQ is high, else IDLE.
//   3. acc_n: cnt+1, stay.
//   4. REQ high but stalled by a full stage: hold state and cnt.
//  Handover: the new port can be accepted on the cycle after the switch; no write is lost or duplicated.
//  Latency: REQ into IDLE -> grant next clk -> accept that clk -> oVRAM_WRITE_REQ next clk (2 clk min).
//   In a granted stream: accept -> VRAM REQ the next clk.
//  No reordering within a port; writes from different ports reach VRAM in acceptance order.
//  Address/data are passed unmodified; no range checking (writers own address validity).
//  Burst counter cannot wrap: rule 1 clears it at P_MAX_BURST-1.
// TESTING
//  T1 reset mid-burst: assert inRESET with valid=1, iVRAM_WAIT=1 -> REQ=0, GRANT=0, WAITs=1 same cycle.
//   After release, the first write appears 2 clk after REQ.
//  T2 single port 0: 3 writes, addr 0x00000..0x00002, data 0xF800, iVRAM_WAIT=0 -> VRAM sees the 3 writes back-to-back.
//   First REQ appears 2 clk after iREQ0_REQ; WAIT0 low for 3 clk.
//  T3 contention: both REQs held continuously, P_MAX_BURST=16 -> 16 port-0 writes, 1 idle-free switch,
//   then 16 port-1 writes, alternating. No write lost; oGRANT toggles 01->10.
//  T4 backpressure: iVRAM_WAIT=1 for 5 clk mid-stream -> ADDR/DATA/REQ stable and WAIT0=1 throughout.
//   Resumes with the next addr and no duplicate.
//  T5 tie after reset: REQ0 and REQ1 rise together -> GNT0 first. Port 0 drops REQ after 2 writes -> GNT1 next clk.
//  T6 single port exceeding burst: 40 writes on port 1 only -> bursts of 16/16/8, one IDLE bubble between bursts.
//   All 40 addresses arrive in order.

Source files
------------

// File: rtl/vram_write_arbiter.sv
// vram_write_arbiter: round-robin, burst-bounded sharing of one VRAM write port between two writers
module vram_write_arbiter #(
  parameter int P_MAX_BURST = 16,
  parameter int P_CNT_W = 4
) (
  input  logic        iCLOCK,
  input  logic        inRESET,
  input  logic        iREQ0_REQ,
  input  logic [18:0] iREQ0_ADDR,
  input  logic [15:0] iREQ0_DATA,
  output logic        oREQ0_WAIT,
  input  logic        iREQ1_REQ,
  input  logic [18:0] iREQ1_ADDR,
  input  logic [15:0] iREQ1_DATA,
  output logic        oREQ1_WAIT,
  output logic        oVRAM_WRITE_REQ,
  output logic [18:0] oVRAM_WRITE_ADDR,
  output logic [15:0] oVRAM_WRITE_DATA,
  input  logic        iVRAM_WAIT,
  output logic [1:0]  oGRANT
);
  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
  state_t state, stateNext;
  logic last, lastNext;
  logic [P_CNT_W-1:0] cnt, cntNext;
  logic valid;
  logic [18:0] addr;
  logic [15:0] data;
  logic free, acc0, acc1, accCur, port, reqCur, reqOth;
  always_comb begin
    free = !valid || !iVRAM_WAIT;
    acc0 = (state == GNT0) && iREQ0_REQ && free;
    acc1 = (state == GNT1) && iREQ1_REQ && free;
    accCur = acc0 || acc1;
    port = state == GNT1;
    reqCur = port ? iREQ1_REQ : iREQ0_REQ;
    reqOth = port ? iREQ0_REQ : iREQ1_REQ;
    stateNext = state;
    lastNext = last;
    cntNext = cnt;
    // last names the port served most recently, so a tie goes to the other one
    if (state == IDLE)
      stateNext = (iREQ0_REQ && (!iREQ1_REQ || last)) ? GNT0 : iREQ1_REQ ? GNT1 : IDLE;
    else if ((accCur && cnt == P_CNT_W'(P_MAX_BURST - 1)) || !reqCur) begin
      cntNext = '0;
      lastNext = port;
      stateNext = !reqOth ? IDLE : port ? GNT0 : GNT1;
    end else if (accCur)
      cntNext = cnt + P_CNT_W'(1);
  end
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state <= IDLE;
      last <= 1'b1;
      cnt <= '0;
      valid <= 1'b0;
      addr <= '0;
      data <= '0;
    end else begin
      state <= stateNext;
      last <= lastNext;
      cnt <= cntNext;
      // refill wins over drain so a stream sustains one write per clock
      if (accCur) begin
        valid <= 1'b1;
        addr <= acc1 ? iREQ1_ADDR : iREQ0_ADDR;
        data <= acc1 ? iREQ1_DATA : iREQ0_DATA;
      end else if (!iVRAM_WAIT)
        valid <= 1'b0;
    end
  end
  assign oREQ0_WAIT = !acc0;
  assign oREQ1_WAIT = !acc1;
  assign oVRAM_WRITE_REQ = valid;
  assign oVRAM_WRITE_ADDR = addr;
  assign oVRAM_WRITE_DATA = data;
  assign oGRANT = {state == GNT1, state == GNT0};
endmodule

// File: tb/tb_vram_write_arbiter.sv
// tb_vram_write_arbiter: directed checks of grant, handshake, output stage, bursts and reset
module tb_vram_write_arbiter;
  logic iCLOCK = 1'b0, inRESET;
  logic iREQ0_REQ, iREQ1_REQ, oREQ0_WAIT, oREQ1_WAIT, oVRAM_WRITE_REQ, iVRAM_WAIT;
  logic [18:0] iREQ0_ADDR, iREQ1_ADDR, oVRAM_WRITE_ADDR;
  logic [15:0] iREQ0_DATA, iREQ1_DATA, oVRAM_WRITE_DATA;
  logic [1:0] oGRANT;
  int vec = 0, mis = 0;
  int n0, n1, lim0, lim1, bcnt;
  logic [18:0] base0, base1;
  logic [1:0] prevG;
  logic [34:0] got[$];
  int bursts[$];
  logic [34:0] e;

  vram_write_arbiter dut (
    .iCLOCK(iCLOCK), .inRESET(inRESET),
    .iREQ0_REQ(iREQ0_REQ), .iREQ0_ADDR(iREQ0_ADDR), .iREQ0_DATA(iREQ0_DATA), .oREQ0_WAIT(oREQ0_WAIT),
    .iREQ1_REQ(iREQ1_REQ), .iREQ1_ADDR(iREQ1_ADDR), .iREQ1_DATA(iREQ1_DATA), .oREQ1_WAIT(oREQ1_WAIT),
    .oVRAM_WRITE_REQ(oVRAM_WRITE_REQ), .oVRAM_WRITE_ADDR(oVRAM_WRITE_ADDR),
    .oVRAM_WRITE_DATA(oVRAM_WRITE_DATA), .iVRAM_WAIT(iVRAM_WAIT), .oGRANT(oGRANT)
  );

  always #5 iCLOCK = ~iCLOCK;

  task automatic chk(input string t, input logic [63:0] obs, input logic [63:0] exp);
    vec++;
    assert (obs === exp) else begin
      mis++;
      $error("FAIL %s: observed %0h expected %0h", t, obs, exp);
    end
  endtask

  task automatic cs(input string t, input logic v, input logic [1:0] g, input logic w0, input logic w1);
    chk({t, ".req"}, 64'(oVRAM_WRITE_REQ), 64'(v));
    chk({t, ".gnt"}, 64'(oGRANT), 64'(g));
    chk({t, ".wait0"}, 64'(oREQ0_WAIT), 64'(w0));
    chk({t, ".wait1"}, 64'(oREQ1_WAIT), 64'(w1));
  endtask

  task automatic ca(input string t, input logic [18:0] a, input logic [15:0] d);
    chk({t, ".addr"}, 64'(oVRAM_WRITE_ADDR), 64'(a));
    chk({t, ".data"}, 64'(oVRAM_WRITE_DATA), 64'(d));
  endtask

  // bench-side writers: each port streams base+n until lim; records bursts and VRAM transfers
  task automatic run(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge iCLOCK);
      iREQ0_REQ = n0 < lim0; iREQ0_ADDR = base0 + 19'(n0); iREQ0_DATA = 16'hA000 ^ 16'(n0);
      iREQ1_REQ = n1 < lim1; iREQ1_ADDR = base1 + 19'(n1); iREQ1_DATA = 16'h5000 ^ 16'(n1);
      #1;
      if (oGRANT !== prevG) begin
        if (prevG != 2'b00) bursts.push_back(bcnt);
        bcnt = 0;
        prevG = oGRANT;
      end
      if (oVRAM_WRITE_REQ && !iVRAM_WAIT) got.push_back({oVRAM_WRITE_ADDR, oVRAM_WRITE_DATA});
      if (iREQ0_REQ && !oREQ0_WAIT) begin n0++; bcnt++; end
      if (iREQ1_REQ && !oREQ1_WAIT) begin n1++; bcnt++; end
    end
  endtask

  task automatic clr;
    got.delete(); bursts.delete();
    n0 = 0; n1 = 0; bcnt = 0; prevG = 2'b00;
  endtask

  initial begin
    inRESET = 1'b0; iVRAM_WAIT = 1'b0;
    iREQ0_REQ = 0; iREQ0_ADDR = '0; iREQ0_DATA = '0;
    iREQ1_REQ = 0; iREQ1_ADDR = '0; iREQ1_DATA = '0;
    #1; cs("rst", 0, 2'b00, 1, 1); ca("rst", 19'h0, 16'h0);
    @(negedge iCLOCK); @(negedge iCLOCK); inRESET = 1'b1;
    // single port 0, three back-to-back writes
    @(negedge iCLOCK); iREQ0_REQ = 1; iREQ0_ADDR = 19'h0; iREQ0_DATA = 16'hF800; #1; cs("t2.c0", 0, 2'b00, 1, 1);
    @(negedge iCLOCK); #1; cs("t2.c1", 0, 2'b01, 0, 1);
    @(negedge iCLOCK); iREQ0_ADDR = 19'h1; #1; cs("t2.c2", 1, 2'b01, 0, 1); ca("t2.c2", 19'h0, 16'hF800);
    @(negedge iCLOCK); iREQ0_ADDR = 19'h2; #1; cs("t2.c3", 1, 2'b01, 0, 1); ca("t2.c3", 19'h1, 16'hF800);
    @(negedge iCLOCK); iREQ0_REQ = 0; #1; cs("t2.c4", 1, 2'b01, 1, 1); ca("t2.c4", 19'h2, 16'hF800);
    @(negedge iCLOCK); #1; cs("t2.c5", 0, 2'b00, 1, 1);
    // backpressure for 5 clocks mid-stream
    @(negedge iCLOCK); iREQ0_REQ = 1; iREQ0_ADDR = 19'h100; iREQ0_DATA = 16'h1111; #1; cs("t4.c0", 0, 2'b00, 1, 1);
    @(negedge iCLOCK); #1; cs("t4.c1", 0, 2'b01, 0, 1);
    @(negedge iCLOCK); iREQ0_ADDR = 19'h101; iREQ0_DATA = 16'h2222; iVRAM_WAIT = 1;
    #1; cs("t4.c2", 1, 2'b01, 1, 1); ca("t4.c2", 19'h100, 16'h1111);
    for (int k = 0; k < 4; k++) begin
      @(negedge iCLOCK); #1; cs("t4.hold", 1, 2'b01, 1, 1); ca("t4.hold", 19'h100, 16'h1111);
    end
    @(negedge iCLOCK); iVRAM_WAIT = 0; #1; cs("t4.c7", 1, 2'b01, 0, 1); ca("t4.c7", 19'h100, 16'h1111);
    @(negedge iCLOCK); iREQ0_REQ = 0; #1; cs("t4.c8", 1, 2'b01, 1, 1); ca("t4.c8", 19'h101, 16'h2222);
    @(negedge iCLOCK); #1; cs("t4.c9", 0, 2'b00, 1, 1);
    // asynchronous reset with a stalled, valid stage
    @(negedge iCLOCK); iREQ0_REQ = 1; iREQ0_ADDR = 19'h400; iREQ0_DATA = 16'h4444; #1; cs("t1.c0", 0, 2'b00, 1, 1);
    @(negedge iCLOCK); #1; cs("t1.c1", 0, 2'b01, 0, 1);
    @(negedge iCLOCK); iREQ0_ADDR = 19'h401; iREQ0_DATA = 16'h5555; iVRAM_WAIT = 1;
    #1; cs("t1.c2", 1, 2'b01, 1, 1); ca("t1.c2", 19'h400, 16'h4444);
    #2; inRESET = 1'b0; #1; cs("t1.rst", 0, 2'b00, 1, 1); ca("t1.rst", 19'h0, 16'h0);
    @(negedge iCLOCK); inRESET = 1'b1; iVRAM_WAIT = 0; #1; cs("t1.r0", 0, 2'b00, 1, 1);
    @(negedge iCLOCK); #1; cs("t1.r1", 0, 2'b01, 0, 1);
    @(negedge iCLOCK); iREQ0_REQ = 0; #1; cs("t1.r2", 1, 2'b01, 1, 1); ca("t1.r2", 19'h401, 16'h5555);
    @(negedge iCLOCK); #1; cs("t1.r3", 0, 2'b00, 1, 1);
    // tie straight after reset goes to port 0; port 0 leaves after two writes
    @(negedge iCLOCK); inRESET = 1'b0;
    @(negedge iCLOCK); inRESET = 1'b1;
    @(negedge iCLOCK);
    iREQ0_REQ = 1; iREQ0_ADDR = 19'h200; iREQ0_DATA = 16'h2020;
    iREQ1_REQ = 1; iREQ1_ADDR = 19'h300; iREQ1_DATA = 16'h3030;
    #1; cs("t5.c0", 0, 2'b00, 1, 1);
    @(negedge iCLOCK); #1; cs("t5.c1", 0, 2'b01, 0, 1);
    @(negedge iCLOCK); iREQ0_ADDR = 19'h201; iREQ0_DATA = 16'h2121; #1; cs("t5.c2", 1, 2'b01, 0, 1); ca("t5.c2", 19'h200, 16'h2020);
    @(negedge iCLOCK); iREQ0_REQ = 0; #1; cs("t5.c3", 1, 2'b01, 1, 1); ca("t5.c3", 19'h201, 16'h2121);
    @(negedge iCLOCK); #1; cs("t5.c4", 0, 2'b10, 1, 0);
    @(negedge iCLOCK); iREQ1_REQ = 0; #1; cs("t5.c5", 1, 2'b10, 1, 1); ca("t5.c5", 19'h300, 16'h3030);
    @(negedge iCLOCK); #1; cs("t5.c6", 0, 2'b00, 1, 1);
    // continuous contention: 16-write bursts alternate with no idle cycle
    clr(); lim0 = 32; lim1 = 32; base0 = 19'h1000; base1 = 19'h2000;
    run(65);
    chk("t3.n0", 64'(n0), 64'd32); chk("t3.n1", 64'(n1), 64'd32);
    run(3);
    chk("t3.nburst", 64'(bursts.size()), 64'd4);
    for (int k = 0; k < 4 && k < bursts.size(); k++) chk("t3.burst", 64'(bursts[k]), 64'd16);
    chk("t3.nwr", 64'(got.size()), 64'd64);
    for (int k = 0; k < 64 && k < got.size(); k++) begin
      int idx;
      idx = (k / 32) * 16 + k % 16;
      e = ((k / 16) % 2 == 1) ? {19'h2000 + 19'(idx), 16'h5000 ^ 16'(idx)} : {19'h1000 + 19'(idx), 16'hA000 ^ 16'(idx)};
      chk("t3.wr", 64'(got[k]), 64'(e));
    end
    // a lone port is re-granted through IDLE after each full burst
    clr(); lim0 = 0; lim1 = 40; base1 = 19'h3000;
    run(42); chk("t6.n1_early", 64'(n1), 64'd39);
    run(1); chk("t6.n1", 64'(n1), 64'd40);
    run(3);
    chk("t6.nburst", 64'(bursts.size()), 64'd3);
    if (bursts.size() == 3) begin
      chk("t6.b0", 64'(bursts[0]), 64'd16); chk("t6.b1", 64'(bursts[1]), 64'd16); chk("t6.b2", 64'(bursts[2]), 64'd8);
    end
    chk("t6.nwr", 64'(got.size()), 64'd40);
    for (int k = 0; k < 40 && k < got.size(); k++) begin
      e = {19'h3000 + 19'(k), 16'h5000 ^ 16'(k)};
      chk("t6.wr", 64'(got[k]), 64'(e));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end
endmodule
